apb_int_ctrl: RTL and testbench



---
 rtl/apb_int_ctrl_pkg.sv | 16 +
 rtl/apb_int_ctrl_if.sv | 18 +
 rtl/apb_int_ctrl_edge_det.sv | 30 +++
 rtl/apb_int_ctrl.sv | 110 +++++++++++
 tb/tb_apb_int_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_int_ctrl_pkg.sv
// Shared constants for the interrupt-controller APB window: bus widths and
// register offsets within the 12-bit decoded address space.
package apb_int_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned APB_ADDR_W = 16;
  localparam int unsigned ADDR_DEC_W = 12;

  localparam logic [ADDR_DEC_W-1:0] OFF_IER   = 12'h000;
  localparam logic [ADDR_DEC_W-1:0] OFF_IPR   = 12'h004;
  localparam logic [ADDR_DEC_W-1:0] OFF_GIE   = 12'h008;
  localparam logic [ADDR_DEC_W-1:0] OFF_RAW   = 12'h00C;
  localparam logic [ADDR_DEC_W-1:0] OFF_ISR   = 12'h010;
  localparam logic [ADDR_DEC_W-1:0] OFF_COUNT = 12'h014;

endpackage

// File: rtl/apb_int_ctrl_if.sv
// APB bus bundle for the interrupt-controller window.
//   iPsel/iPenable/iPwrite/iPaddr/iPwdata : initiator -> responder
//   oPrdata                               : responder -> initiator
interface apb_int_ctrl_if;
  import apb_int_pkg::*;

  logic                  iPsel;
  logic                  iPenable;
  logic                  iPwrite;
  logic [APB_ADDR_W-1:0] iPaddr;
  logic [DATA_W-1:0]     iPwdata;
  logic [DATA_W-1:0]     oPrdata;

  modport master (output iPsel, iPenable, iPwrite, iPaddr, iPwdata,
                  input  oPrdata);
  modport slave  (input  iPsel, iPenable, iPwrite, iPaddr, iPwdata,
                  output oPrdata);
endinterface

// File: rtl/apb_int_ctrl_edge_det.sv
// Source history register and rising-edge detector for the interrupt inputs.
//   iClk, iRsn : clock, synchronous active-low reset
//   iSrc       : raw source levels
//   oSrc       : source levels registered one cycle (history / RAW view)
//   oRise_c    : combinational one-cycle rise pulse per source
module int_edge_det #(
  parameter int unsigned NUM_SRC = 4
) (
  input  logic               iClk,
  input  logic               iRsn,
  input  logic [NUM_SRC-1:0] iSrc,
  output logic [NUM_SRC-1:0] oSrc,
  output logic [NUM_SRC-1:0] oRise_c
);

  logic [NUM_SRC-1:0] src_q, src_d;

  always_comb begin
    src_d   = iSrc;
    oRise_c = iSrc & ~src_q;
  end

  always_ff @(posedge iClk) begin
    if (!iRsn) src_q <= '0;
    else       src_q <= src_d;
  end

  assign oSrc = src_q;

endmodule

// File: rtl/apb_int_ctrl.sv
// APB responder for the interrupt controller: pending latch of source rises,
// per-source and global enables, software trigger, saturating event counter.
//   iClk, iRsn : clock, synchronous active-low reset
//   apb        : APB slave port (zero wait states, always ready)
//   iIntSrc    : interrupt sources, active high
//   oInt       : registered level interrupt to host
module apb_int_ctrl
  import apb_int_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               iClk,
  input  logic               iRsn,
  apb_int_ctrl_if.slave      apb,
  input  logic [NUM_SRC-1:0] iIntSrc,
  output logic               oInt
);

  logic [NUM_SRC-1:0]    ier_q, ier_d;
  logic [NUM_SRC-1:0]    ipr_q, ipr_d;
  logic                  gie_q, gie_d;
  logic                  int_q, int_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     prdata_q, prdata_d;

  logic [NUM_SRC-1:0]    src_q, rise_c, w1c_c, isr_c;
  logic [ADDR_DEC_W-1:0] off_c;
  logic                  wr_c, rd_c, cnt_clr_c, set_any_c;
  logic                  unused_c;

  int_edge_det #(.NUM_SRC(NUM_SRC)) u_edge_det (
    .iClk    (iClk),
    .iRsn    (iRsn),
    .iSrc    (iIntSrc),
    .oSrc    (src_q),
    .oRise_c (rise_c)
  );

  // Writes commit at the end of the access phase; reads capture at the end of setup
  assign off_c    = apb.iPaddr[ADDR_DEC_W-1:0];
  assign wr_c     = apb.iPsel &  apb.iPenable &  apb.iPwrite;
  assign rd_c     = apb.iPsel & ~apb.iPenable & ~apb.iPwrite;
  assign unused_c = ^{apb.iPaddr, apb.iPwdata};

  // Register write decode, read mux and next-state logic
  always_comb begin
    ier_d     = ier_q;
    gie_d     = gie_q;
    prdata_d  = prdata_q;
    w1c_c     = '0;
    isr_c     = '0;
    cnt_clr_c = 1'b0;

    if (wr_c) begin
      case (off_c)
        OFF_IER:   ier_d     = apb.iPwdata[NUM_SRC-1:0];
        OFF_IPR:   w1c_c     = apb.iPwdata[NUM_SRC-1:0];
        OFF_GIE:   gie_d     = apb.iPwdata[0];
        OFF_ISR:   isr_c     = apb.iPwdata[NUM_SRC-1:0];
        OFF_COUNT: cnt_clr_c = 1'b1;
        default:   ;
      endcase
    end

    if (rd_c) begin
      case (off_c)
        OFF_IER:   prdata_d = DATA_W'(ier_q);
        OFF_IPR:   prdata_d = DATA_W'(ipr_q);
        OFF_GIE:   prdata_d = DATA_W'(gie_q);
        OFF_RAW:   prdata_d = DATA_W'(src_q);
        OFF_COUNT: prdata_d = DATA_W'(cnt_q);
        default:   prdata_d = '0;
      endcase
    end

    // Set terms are OR'd after the clear so a same-cycle set wins
    ipr_d     = (ipr_q & ~w1c_c) | rise_c | isr_c;
    set_any_c = |(ipr_d & ~ipr_q);

    if (cnt_clr_c)                    cnt_d = CNT_W'(set_any_c);
    else if (set_any_c && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    else                              cnt_d = cnt_q;

    // Built from next-state values so the flop shows the post-edge register state
    int_d = gie_d & (|(ipr_d & ier_d));
  end

  always_ff @(posedge iClk) begin
    if (!iRsn) begin
      ier_q    <= '0;
      ipr_q    <= '0;
      gie_q    <= 1'b0;
      int_q    <= 1'b0;
      cnt_q    <= '0;
      prdata_q <= '0;
    end else begin
      ier_q    <= ier_d;
      ipr_q    <= ipr_d;
      gie_q    <= gie_d;
      int_q    <= int_d;
      cnt_q    <= cnt_d;
      prdata_q <= prdata_d;
    end
  end

  assign apb.oPrdata = prdata_q;
  assign oInt        = int_q;

endmodule

// File: tb/tb_apb_int_ctrl.sv
// Scoreboard bench for apb_int_ctrl: a transaction-level model pushes expected
// read data and interrupt levels; a negedge monitor pops and compares.
module tb_apb_int_ctrl;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CMAX    = (1 << CNT_W) - 1;
  localparam int unsigned MASK    = (1 << NUM_SRC) - 1;

  typedef struct {
    logic [31:0] val;
    logic [11:0] off;
  } rd_exp_t;

  logic               clk = 1'b0;
  logic               rsn;
  logic [NUM_SRC-1:0] src;
  logic               oint;

  apb_int_ctrl_if bus();

  apb_int_ctrl #(.NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) u_dut (
    .iClk    (clk),
    .iRsn    (rsn),
    .apb     (bus),
    .iIntSrc (src),
    .oInt    (oint)
  );

  always #5 clk = ~clk;

  // Reference state
  int unsigned m_ier, m_ipr, m_gie, m_cnt, m_srcq;
  rd_exp_t     exp_rd_q[$];
  logic        exp_int_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] off);
    case (off)
      12'h000: return m_ier;
      12'h004: return m_ipr;
      12'h008: return m_gie;
      12'h00C: return m_srcq;
      12'h014: return m_cnt;
      default: return 32'h0;
    endcase
  endfunction

  // Apply the register rules for the upcoming clock edge using current inputs
  task automatic model_step();
    int unsigned rise, w1c, isr, nipr, newly;
    logic [11:0] off;
    bit wr, rd;
    rd_exp_t e;
    if (!rsn) begin
      m_ier = 0; m_ipr = 0; m_gie = 0; m_cnt = 0; m_srcq = 0;
      exp_int_q.push_back(1'b0);
      return;
    end
    off = bus.iPaddr[11:0];
    wr  = bus.iPsel && bus.iPenable && bus.iPwrite;
    rd  = bus.iPsel && !bus.iPenable && !bus.iPwrite;
    if (rd) begin
      e.val = model_read(off);
      e.off = off;
      exp_rd_q.push_back(e);
    end
    rise = int'(src) & ~m_srcq & MASK;
    w1c  = (wr && off == 12'h004) ? (bus.iPwdata & MASK) : 0;
    isr  = (wr && off == 12'h010) ? (bus.iPwdata & MASK) : 0;
    nipr  = (m_ipr & ~w1c) | rise | isr;
    newly = nipr & ~m_ipr;
    if (wr && off == 12'h014)           m_cnt = (newly != 0) ? 1 : 0;
    else if (newly != 0 && m_cnt < CMAX) m_cnt = m_cnt + 1;
    if (wr && off == 12'h000) m_ier = bus.iPwdata & MASK;
    if (wr && off == 12'h008) m_gie = bus.iPwdata & 1;
    m_ipr  = nipr;
    m_srcq = int'(src);
    exp_int_q.push_back((m_gie != 0) && ((m_ipr & m_ier) != 0));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apb_write(input logic [15:0] addr, input logic [31:0] data);
    bus.iPsel = 1'b1; bus.iPenable = 1'b0; bus.iPwrite = 1'b1;
    bus.iPaddr = addr; bus.iPwdata = data;
    tick();
    bus.iPenable = 1'b1;
    tick();
    bus.iPsel = 1'b0; bus.iPenable = 1'b0;
  endtask

  task automatic apb_read(input logic [15:0] addr);
    bus.iPsel = 1'b1; bus.iPenable = 1'b0; bus.iPwrite = 1'b0;
    bus.iPaddr = addr; bus.iPwdata = $urandom;
    tick();
    bus.iPenable = 1'b1;
    tick();
    bus.iPsel = 1'b0; bus.iPenable = 1'b0;
  endtask

  task automatic pulse(input int bitn);
    src[bitn] = 1'b1;
    tick();
    src[bitn] = 1'b0;
    tick();
  endtask

  // Monitor: interrupt level every cycle, read data during each read access phase
  always @(negedge clk) begin
    logic    ei;
    rd_exp_t er;
    if (exp_int_q.size() > 0) begin
      ei = exp_int_q.pop_front();
      check("oInt", 32'(oint), 32'(ei));
    end
    if (rsn === 1'b1 && bus.iPsel && bus.iPenable && !bus.iPwrite) begin
      if (exp_rd_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rd_queue: read access with no expected entry, got %08h", bus.oPrdata);
      end else begin
        er = exp_rd_q.pop_front();
        check($sformatf("rd@%03h", er.off), bus.oPrdata, er.val);
      end
    end
  end

  localparam logic [11:0] OFFS [7] = '{12'h000, 12'h004, 12'h008, 12'h00C,
                                       12'h010, 12'h014, 12'h020};

  initial begin
    rsn = 1'b0; src = '0;
    bus.iPsel = 1'b0; bus.iPenable = 1'b0; bus.iPwrite = 1'b0;
    bus.iPaddr = '0; bus.iPwdata = '0;
    m_ier = 0; m_ipr = 0; m_gie = 0; m_cnt = 0; m_srcq = 0;
    #2;
    idle(3);
    rsn = 1'b1;
    idle(1);

    // Reset values
    apb_read(16'h0000); apb_read(16'h0004); apb_read(16'h0008); apb_read(16'h0014);

    // Enable flow
    apb_write(16'h0000, 32'h1);
    apb_write(16'h0008, 32'h1);
    pulse(0);
    apb_read(16'h0004);
    apb_write(16'h0004, 32'h1);
    apb_read(16'h0004);

    // Masking
    apb_write(16'h0000, 32'h0);
    pulse(2);
    apb_read(16'h0004);
    apb_write(16'h0000, 32'h4);
    idle(1);
    apb_write(16'h0004, 32'h4);

    // Level source held high
    apb_write(16'h0014, 32'h0);
    src[1] = 1'b1;
    idle(20);
    apb_read(16'h0004); apb_read(16'h0014); apb_read(16'h000C);
    apb_write(16'h0004, 32'h2);
    apb_read(16'h0004); apb_read(16'h0014);
    src[1] = 1'b0;
    idle(1);

    // Collision: W1C on bit0 with a new rise on source 0 in the same edge
    apb_write(16'h0000, 32'h1);
    pulse(0);
    bus.iPsel = 1'b1; bus.iPenable = 1'b0; bus.iPwrite = 1'b1;
    bus.iPaddr = 16'h0004; bus.iPwdata = 32'h1;
    tick();
    bus.iPenable = 1'b1; src[0] = 1'b1;
    tick();
    bus.iPsel = 1'b0; bus.iPenable = 1'b0; src[0] = 1'b0;
    tick();
    apb_read(16'h0004); apb_read(16'h0014);

    // Software trigger, counter clear, undefined offset
    apb_write(16'h0004, 32'hF);
    apb_write(16'h0014, 32'h0);
    apb_write(16'h0010, 32'h3);
    apb_read(16'h0004); apb_read(16'h0014); apb_read(16'h0010);
    apb_write(16'h0014, 32'h0);
    apb_read(16'h0014);
    apb_write(16'h0020, 32'hFFFF_FFFF);
    apb_read(16'h0020);
    apb_read(16'hF008);

    // Counter saturation
    for (int i = 0; i < 20; i++) begin
      apb_write(16'h0004, 32'hF);
      apb_write(16'h0010, 32'h1);
    end
    apb_read(16'h0014);

    // Reset asserted during a write access phase
    apb_write(16'h0000, 32'hF);
    bus.iPsel = 1'b1; bus.iPenable = 1'b0; bus.iPwrite = 1'b1;
    bus.iPaddr = 16'h0010; bus.iPwdata = 32'hF;
    tick();
    bus.iPenable = 1'b1; rsn = 1'b0;
    tick();
    bus.iPsel = 1'b0; bus.iPenable = 1'b0; rsn = 1'b1;
    tick();
    apb_read(16'h0000); apb_read(16'h0004); apb_read(16'h0008);
    apb_read(16'h0014); apb_read(16'h000C);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      int op;
      src = NUM_SRC'($urandom);
      a   = {4'($urandom), OFFS[$urandom_range(0, 6)]};
      op  = int'($urandom_range(0, 3));
      case (op)
        0:       apb_read(a);
        1:       apb_write(a, $urandom);
        2:       apb_write(a, 32'($urandom_range(0, 15)));
        default: idle(int'($urandom_range(1, 3)));
      endcase
    end
    src = '0;
    idle(2);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_rd_q.size() != 0) begin
      n_errors++;
      $display("FAIL rd_drain: %0d expected reads never observed, required 0", exp_rd_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit, required completion");
    $fatal(1, "timeout");
  end

endmodule
